memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Consumer end of the EX/MEM pipeline register: takes the execute stage's registered outputs, performs data-memory load/store and stack push/pop, and drives the MEM/WB pipeline register.
- Owns the stack pointer (SP) and a 16-bit-word data memory.
- Runs a small FSM that splits 32-bit PC push (CALL/INT) and PC pop (RET/RTI) into two word accesses, stalling upstream stages for one cycle.

Parameters:
- ADDR_WIDTH, 12, data-memory address bits; depth = 2^ADDR_WIDTH words of 16 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- result_in  in  16  ALU result from EX/MEM
- read_data1, read_data2  in  16 each  Rdest / Rsrc values from EX/MEM
- pc_plus_one  in  32  return address
- flags_in  in  3  {carry, negative, zero}
- mem_read, mem_write, mem_push, mem_pop  in  1 each  memory controls
- memory_address_select  in  2  00 result_in, 01 SP, 10 SP+1, 11 read_data2
- memory_write_src_select  in  2  00 read_data1, 01 read_data2, 10 PC (two-word), 11 {13'b0, flags_in}
- pc_choose_memory  in  1  pop targets PC (two-word)
- flags_pop  in  1  popped word restores flags
- reg_write, outport_enable  in  1 each  pass-through
- wb_sel  in  2  pass-through
- reg_write_address  in  3  pass-through
- LDM_value, input_port  in  16 each  pass-through
- mem_data_out  out  16  registered read data
- result_out, LDM_value_out, input_port_out, read_data1_out  out  16 each  registered
- reg_write_out, outport_enable_out  out  1 each  registered
- wb_sel_out  out  2  registered
- reg_write_address_out  out  3  registered; also the forwarding-unit MEM/WB rdest
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
- pc_from_memory  out  32  registered popped PC
- pc_load  out  1  registered one-cycle pulse
- flags_restore  out  3  registered
- flags_restore_valid  out  1  registered one-cycle pulse

Behaviour:
- Reset (async): all registered outputs 0; SP = 2^ADDR_WIDTH-1; FSM = IDLE; memory contents not cleared.
- Address:
  - selected source truncated to ADDR_WIDTH LSBs; SP arithmetic wraps modulo 2^ADDR_WIDTH.
  - Reads are combinational from the array and captured into mem_data_out at the edge, so data reaches WB one cycle after the MEM cycle.
- Store: mem_write and not mem_push → mem[addr] <= write source at the edge.
- Push (single word, src != 10): mem[SP] <= source; SP <= SP-1.
- Pop (single word, not pc_choose_memory): mem_data_out <= mem[SP+1]; SP <= SP+1.
  - If flags_pop: flags_restore <= mem[SP+1][2:0]; flags_restore_valid pulses 1 cycle.
- Conflicts:
  - mem_push and mem_pop together: no write, SP unchanged, outputs pass as a normal non-memory op.
  - mem_push has priority over mem_write.
- FSM states: IDLE, PUSH_LO, POP_HI.
  - IDLE, mem_push and src=10:
    - write pc_plus_one[31:16] at SP, SP-1, stall=1 → PUSH_LO.
    - MEM/WB loads a bubble (reg_write_out=0, outport_enable_out=0).
  - PUSH_LO: write pc_plus_one[15:0] at SP, SP-1, stall=0, MEM/WB loads the instruction normally → IDLE.
  - IDLE, mem_pop and pc_choose_memory:
    - latch low half = mem[SP+1], SP+1, stall=1, bubble → POP_HI.
  - POP_HI:
    - high half = mem[SP+1], SP+1, stall=0.
    - At the edge: pc_from_memory <= {high, low_latched}, pc_load <= 1 for one cycle.
    - If flags_pop is also set, it applies after the PC pop (third word, next instruction issued by decode). → IDLE.
- Stall is high only in the first cycle of a two-word op. Upstream holds EX/MEM stable, so inputs are identical in both cycles.
- Reset mid-operation: FSM returns to IDLE, SP returns to top, and no partial pc_load is issued.
- Pass-through fields are registered with 1-cycle latency every cycle, except during bubbles.

Test Plan:
- Reset, then push read_data1=0x1234 → mem[0xFFF]=0x1234, SP=0xFFE; then pop → SP=0xFFF, mem_data_out=0x1234 one cycle later.
- CALL push, pc_plus_one=0x0001_0020, SP=0xFFF → stall high exactly 1 cycle; mem[0xFFF]=0x0001, mem[0xFFE]=0x0020, SP=0xFFD.
- Continue with RET pop (pc_choose_memory) → stall 1 cycle; pc_load single pulse with pc_from_memory=0x0001_0020; SP=0xFFF.
- Store result_in=0x0005 with read_data2=0xBEEF (src 01), then load addr 0x0005 → mem_data_out=0xBEEF; SP unchanged.
- SP=0xFFF, pop → SP wraps to 0x000, reading mem[0x000]. Push and pop asserted together → SP unchanged, no write.
- Assert reset during PUSH_LO → stall=0, SP=0xFFF, pc_load=0, all registered outputs 0.

Source files
------------

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM pipeline stage: data memory, stack pointer and two-word PC push/pop sequencing
module memory_stage #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result_in,
    input  logic [15:0] read_data1,
    input  logic [15:0] read_data2,
    input  logic [31:0] pc_plus_one,
    input  logic [2:0]  flags_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_push,
    input  logic        mem_pop,
    input  logic [1:0]  memory_address_select,
    input  logic [1:0]  memory_write_src_select,
    input  logic        pc_choose_memory,
    input  logic        flags_pop,
    input  logic        reg_write,
    input  logic        outport_enable,
    input  logic [1:0]  wb_sel,
    input  logic [2:0]  reg_write_address,
    input  logic [15:0] LDM_value,
    input  logic [15:0] input_port,
    output logic [15:0] mem_data_out,
    output logic [15:0] result_out,
    output logic [15:0] LDM_value_out,
    output logic [15:0] input_port_out,
    output logic [15:0] read_data1_out,
    output logic        reg_write_out,
    output logic        outport_enable_out,
    output logic [1:0]  wb_sel_out,
    output logic [2:0]  reg_write_address_out,
    output logic        stall,
    output logic [31:0] pc_from_memory,
    output logic        pc_load,
    output logic [2:0]  flags_restore,
    output logic        flags_restore_valid
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PUSH_LO = 2'b01,
        S_POP_HI  = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_sp;
    logic [ADDR_WIDTH-1:0] w_sp_next;
    logic [ADDR_WIDTH-1:0] w_sp_inc;
    logic [ADDR_WIDTH-1:0] w_sp_dec;
    logic [15:0]           r_mem [DEPTH];
    logic [15:0]           r_pop_lo;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_pc_push;
    logic                  w_pc_pop;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [15:0]           w_rd_data;
    logic [15:0]           w_wdata;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_bubble;
    logic                  w_latch_lo;
    logic                  w_pc_done;
    logic                  w_flags_pop;
    logic                  w_stall;

    // Simultaneous push and pop cancel each other and behave as a plain ALU op.
    assign w_push    = mem_push & ~mem_pop;
    assign w_pop     = mem_pop & ~mem_push;
    assign w_pc_push = w_push & (memory_write_src_select == 2'b10);
    assign w_pc_pop  = w_pop & pc_choose_memory;
    assign w_sp_inc  = r_sp + 1'b1;
    assign w_sp_dec  = r_sp - 1'b1;

    always_comb begin
        w_addr = r_sp;
        case (memory_address_select)
            2'b00:   w_addr = result_in[ADDR_WIDTH-1:0];
            2'b01:   w_addr = r_sp;
            2'b10:   w_addr = w_sp_inc;
            default: w_addr = read_data2[ADDR_WIDTH-1:0];
        endcase
    end

    always_comb begin
        w_wdata = read_data1;
        case (memory_write_src_select)
            2'b00:   w_wdata = read_data1;
            2'b01:   w_wdata = read_data2;
            2'b10:   w_wdata = (r_state == S_PUSH_LO) ? pc_plus_one[15:0] : pc_plus_one[31:16];
            default: w_wdata = {13'b0, flags_in};
        endcase
    end

    assign w_rd_addr = w_pop ? w_sp_inc : w_addr;
    assign w_rd_data = r_mem[w_rd_addr];

    always_comb begin
        w_next_state = r_state;
        w_sp_next    = r_sp;
        w_we         = 1'b0;
        w_wr_addr    = w_addr;
        w_bubble     = 1'b0;
        w_latch_lo   = 1'b0;
        w_pc_done    = 1'b0;
        w_flags_pop  = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pc_push) begin
                    w_we         = 1'b1;
                    w_wr_addr    = r_sp;
                    w_sp_next    = w_sp_dec;
                    w_stall      = 1'b1;
                    w_bubble     = 1'b1;
                    w_next_state = S_PUSH_LO;
                end else if (w_pc_pop) begin
                    w_sp_next    = w_sp_inc;
                    w_latch_lo   = 1'b1;
                    w_stall      = 1'b1;
                    w_bubble     = 1'b1;
                    w_next_state = S_POP_HI;
                end else if (w_push) begin
                    w_we      = 1'b1;
                    w_wr_addr = r_sp;
                    w_sp_next = w_sp_dec;
                end else if (w_pop) begin
                    w_sp_next   = w_sp_inc;
                    w_flags_pop = flags_pop;
                end else if (mem_write && !mem_push) begin
                    w_we      = 1'b1;
                    w_wr_addr = w_addr;
                end
            end
            S_PUSH_LO: begin
                w_we         = 1'b1;
                w_wr_addr    = r_sp;
                w_sp_next    = w_sp_dec;
                w_next_state = S_IDLE;
            end
            // A flags_pop riding on RET is handled later by its own decoded pop.
            S_POP_HI: begin
                w_sp_next    = w_sp_inc;
                w_pc_done    = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign stall = w_stall & ~reset;

    always_ff @(posedge clk) begin
        if (w_we && !reset) begin
            r_mem[w_wr_addr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state               <= S_IDLE;
            r_sp                  <= '1;
            r_pop_lo              <= 16'h0000;
            mem_data_out          <= 16'h0000;
            result_out            <= 16'h0000;
            LDM_value_out         <= 16'h0000;
            input_port_out        <= 16'h0000;
            read_data1_out        <= 16'h0000;
            reg_write_out         <= 1'b0;
            outport_enable_out    <= 1'b0;
            wb_sel_out            <= 2'b00;
            reg_write_address_out <= 3'b000;
            pc_from_memory        <= 32'h0000_0000;
            pc_load               <= 1'b0;
            flags_restore         <= 3'b000;
            flags_restore_valid   <= 1'b0;
        end else begin
            r_state               <= w_next_state;
            r_sp                  <= w_sp_next;
            mem_data_out          <= w_rd_data;
            result_out            <= result_in;
            LDM_value_out         <= LDM_value;
            input_port_out        <= input_port;
            read_data1_out        <= read_data1;
            reg_write_out         <= reg_write & ~w_bubble;
            outport_enable_out    <= outport_enable & ~w_bubble;
            wb_sel_out            <= wb_sel;
            reg_write_address_out <= reg_write_address;
            pc_load               <= w_pc_done;
            flags_restore_valid   <= w_flags_pop;
            if (w_latch_lo) begin
                r_pop_lo <= w_rd_data;
            end
            if (w_pc_done) begin
                pc_from_memory <= {w_rd_data, r_pop_lo};
            end
            if (w_flags_pop) begin
                flags_restore <= w_rd_data[2:0];
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized scoreboard bench for memory_stage against a word-level stack/memory model
module tb_memory_stage;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] result_in, read_data1, read_data2, LDM_value, input_port;
    logic [31:0] pc_plus_one;
    logic [2:0]  flags_in, reg_write_address;
    logic        mem_read, mem_write, mem_push, mem_pop, pc_choose_memory, flags_pop;
    logic        reg_write, outport_enable;
    logic [1:0]  memory_address_select, memory_write_src_select, wb_sel;
    logic [15:0] mem_data_out, result_out, LDM_value_out, input_port_out, read_data1_out;
    logic        reg_write_out, outport_enable_out, stall, pc_load, flags_restore_valid;
    logic [1:0]  wb_sel_out;
    logic [2:0]  reg_write_address_out, flags_restore;
    logic [31:0] pc_from_memory;

    memory_stage #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .reset(reset), .result_in(result_in), .read_data1(read_data1),
        .read_data2(read_data2), .pc_plus_one(pc_plus_one), .flags_in(flags_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select),
        .pc_choose_memory(pc_choose_memory), .flags_pop(flags_pop), .reg_write(reg_write),
        .outport_enable(outport_enable), .wb_sel(wb_sel), .reg_write_address(reg_write_address),
        .LDM_value(LDM_value), .input_port(input_port), .mem_data_out(mem_data_out),
        .result_out(result_out), .LDM_value_out(LDM_value_out), .input_port_out(input_port_out),
        .read_data1_out(read_data1_out), .reg_write_out(reg_write_out),
        .outport_enable_out(outport_enable_out), .wb_sel_out(wb_sel_out),
        .reg_write_address_out(reg_write_address_out), .stall(stall),
        .pc_from_memory(pc_from_memory), .pc_load(pc_load), .flags_restore(flags_restore),
        .flags_restore_valid(flags_restore_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        chk_pass;
        logic [15:0] result;
        logic [15:0] ldm;
        logic [15:0] inport;
        logic [15:0] rd1;
        logic [1:0]  wb_sel;
        logic [2:0]  rwa;
        logic        rw;
        logic        oe;
        logic        chk_data;
        logic [15:0] data;
        logic        pc_load;
        logic        chk_pc;
        logic [31:0] pc;
        logic        fv;
        logic        chk_flags;
        logic [2:0]  flags;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [11:0] m_sp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: stall is sampled mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        logic s;
        forever begin
            @(negedge clk);
            #2 s = stall;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 32'(s), 32'(e.stall));
                if (e.chk_pass) begin
                    chk("result_out", 32'(result_out), 32'(e.result));
                    chk("LDM_value_out", 32'(LDM_value_out), 32'(e.ldm));
                    chk("input_port_out", 32'(input_port_out), 32'(e.inport));
                    chk("read_data1_out", 32'(read_data1_out), 32'(e.rd1));
                    chk("wb_sel_out", 32'(wb_sel_out), 32'(e.wb_sel));
                    chk("reg_write_address_out", 32'(reg_write_address_out), 32'(e.rwa));
                end
                chk("reg_write_out", 32'(reg_write_out), 32'(e.rw));
                chk("outport_enable_out", 32'(outport_enable_out), 32'(e.oe));
                if (e.chk_data) chk("mem_data_out", 32'(mem_data_out), 32'(e.data));
                chk("pc_load", 32'(pc_load), 32'(e.pc_load));
                if (e.chk_pc) chk("pc_from_memory", pc_from_memory, e.pc);
                chk("flags_restore_valid", 32'(flags_restore_valid), 32'(e.fv));
                if (e.chk_flags) chk("flags_restore", 32'(flags_restore), 32'(e.flags));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t pass_exp(input bit bubble);
        exp_t e;
        e = '0;
        e.chk_pass = !bubble;
        e.result   = result_in;
        e.ldm      = LDM_value;
        e.inport   = input_port;
        e.rd1      = read_data1;
        e.wb_sel   = wb_sel;
        e.rwa      = reg_write_address;
        e.rw       = reg_write & !bubble;
        e.oe       = outport_enable & !bubble;
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e = '0;
        e.chk_pass  = 1'b1;
        e.chk_data  = 1'b1;
        e.chk_pc    = 1'b1;
        e.chk_flags = 1'b1;
        return e;
    endfunction

    function automatic logic [15:0] wdata_of();
        case (memory_write_src_select)
            2'b00:   return read_data1;
            2'b01:   return read_data2;
            2'b11:   return {13'b0, flags_in};
            default: return pc_plus_one[31:16];
        endcase
    endfunction

    task automatic issue(input exp_t e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rand_pass();
        result_in         = 16'($urandom);
        read_data1        = 16'($urandom);
        read_data2        = 16'($urandom);
        LDM_value         = 16'($urandom);
        input_port        = 16'($urandom);
        pc_plus_one       = $urandom;
        flags_in          = 3'($urandom);
        reg_write         = 1'($urandom);
        outport_enable    = 1'($urandom);
        wb_sel            = 2'($urandom);
        reg_write_address = 3'($urandom);
    endtask

    task automatic clear_ctrl();
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        pc_choose_memory = 0; flags_pop = 0;
        memory_address_select = 2'b00; memory_write_src_select = 2'b00;
    endtask

    task automatic set_src_data(input logic [1:0] src, input logic [15:0] data);
        memory_write_src_select = src;
        case (src)
            2'b00:   read_data1 = data;
            2'b01:   read_data2 = data;
            default: flags_in = data[2:0];
        endcase
    endtask

    task automatic op_nop();
        rand_pass(); clear_ctrl();
        issue(pass_exp(0));
    endtask

    task automatic op_store(input logic [11:0] addr, input logic [1:0] src, input logic [1:0] sel,
                            input logic [15:0] data);
        rand_pass(); clear_ctrl();
        mem_write = 1;
        memory_address_select = sel;
        set_src_data(src, data);
        if (sel == 2'b11) read_data2 = {4'($urandom), addr};
        else result_in = {4'($urandom), addr};
        m_mem[addr] = wdata_of();
        m_known[addr] = 1;
        issue(pass_exp(0));
    endtask

    task automatic op_load(input logic [11:0] addr, input logic [1:0] sel);
        exp_t e;
        logic [11:0] a;
        rand_pass(); clear_ctrl();
        mem_read = 1;
        memory_address_select = sel;
        if (sel == 2'b00) result_in = {4'($urandom), addr};
        if (sel == 2'b11) read_data2 = {4'($urandom), addr};
        a = (sel == 2'b01) ? m_sp : (sel == 2'b10) ? m_sp + 12'd1 : addr;
        e = pass_exp(0);
        e.chk_data = m_known[a];
        e.data = m_mem[a];
        issue(e);
    endtask

    task automatic op_push(input logic [1:0] src, input logic [15:0] data);
        rand_pass(); clear_ctrl();
        mem_push = 1;
        mem_write = 1'($urandom);
        memory_address_select = 2'($urandom);
        set_src_data(src, data);
        m_mem[m_sp] = wdata_of();
        m_known[m_sp] = 1;
        m_sp = m_sp - 12'd1;
        issue(pass_exp(0));
    endtask

    task automatic op_pop(input bit fp);
        exp_t e;
        logic [11:0] a;
        rand_pass(); clear_ctrl();
        mem_pop = 1;
        flags_pop = fp;
        memory_address_select = 2'b10;
        a = m_sp + 12'd1;
        e = pass_exp(0);
        e.chk_data = m_known[a];
        e.data = m_mem[a];
        e.fv = fp;
        e.chk_flags = fp && m_known[a];
        e.flags = m_mem[a][2:0];
        m_sp = a;
        issue(e);
    endtask

    task automatic op_call(input logic [31:0] pc, input bit abort);
        exp_t e;
        rand_pass(); clear_ctrl();
        mem_push = 1;
        memory_write_src_select = 2'b10;
        memory_address_select = 2'b01;
        pc_plus_one = pc;
        e = pass_exp(1);
        e.stall = 1;
        m_mem[m_sp] = pc[31:16];
        m_known[m_sp] = 1;
        m_sp = m_sp - 12'd1;
        issue(e);
        if (abort) begin
            reset = 1;
            m_sp = 12'hFFF;
            issue(zero_exp());
            reset = 0;
        end else begin
            m_mem[m_sp] = pc[15:0];
            m_known[m_sp] = 1;
            m_sp = m_sp - 12'd1;
            issue(pass_exp(0));
        end
    endtask

    task automatic op_ret();
        exp_t e;
        logic [11:0] lo_a, hi_a;
        rand_pass(); clear_ctrl();
        mem_pop = 1;
        pc_choose_memory = 1;
        flags_pop = 1'($urandom);
        memory_address_select = 2'b10;
        lo_a = m_sp + 12'd1;
        hi_a = m_sp + 12'd2;
        e = pass_exp(1);
        e.stall = 1;
        issue(e);
        e = pass_exp(0);
        e.pc_load = 1;
        e.chk_pc = m_known[lo_a] && m_known[hi_a];
        e.pc = {m_mem[hi_a], m_mem[lo_a]};
        m_sp = hi_a;
        issue(e);
    endtask

    task automatic op_pushpop();
        rand_pass(); clear_ctrl();
        mem_push = 1;
        mem_pop = 1;
        mem_write = 1'($urandom);
        pc_choose_memory = 1'($urandom);
        flags_pop = 1'($urandom);
        memory_write_src_select = 2'($urandom);
        memory_address_select = 2'($urandom);
        issue(pass_exp(0));
    endtask

    function automatic logic [1:0] rand_src();
        int s;
        s = $urandom_range(0, 2);
        return (s == 2) ? 2'b11 : 2'(s);
    endfunction

    function automatic logic [11:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return {8'hFF, 4'($urandom)};
        return 12'($urandom_range(0, 31));
    endfunction

    initial begin
        reset = 1;
        rand_pass();
        clear_ctrl();
        m_sp = 12'hFFF;
        @(negedge clk);
        issue(zero_exp());
        reset = 0;

        op_push(2'b00, 16'h1234);
        op_pop(0);
        op_call(32'h0001_0020, 0);
        op_load(12'hFFF, 2'b00);
        op_load(12'hFFE, 2'b11);
        op_ret();
        op_store(12'h005, 2'b01, 2'b00, 16'hBEEF);
        op_load(12'h005, 2'b00);
        op_store(12'h000, 2'b00, 2'b11, 16'hA5A5);
        op_pop(1);
        op_push(2'b00, 16'h0C3C);
        op_pushpop();
        op_pop(0);
        op_load(12'hFFF, 2'b00);
        op_push(2'b11, 16'h0006);
        op_call(32'hDEAD_BEEF, 1);
        op_load(12'hFFF, 2'b00);
        op_pop(1);
        op_nop();

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0: op_nop();
                1: op_store(rand_addr(), rand_src(), ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00,
                            16'($urandom));
                2: op_load(rand_addr(), 2'($urandom));
                3: op_push(rand_src(), 16'($urandom));
                4: op_pop(1'($urandom));
                5: op_call($urandom, 0);
                6: op_ret();
                default: op_pushpop();
            endcase
        end

        clear_ctrl();
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
